// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared vertex/triangle types and cull modes for raster setup
package graphics_pkg;
  localparam int COORD_W = 17;
  localparam int AREA_W  = 34;

  typedef logic [1:0][COORD_W-1:0] vertex_t;
  typedef vertex_t [2:0] triangle_t;

  typedef enum logic [1:0] {
    CULL_NONE = 2'd0,
    CULL_NEG  = 2'd1,
    CULL_POS  = 2'd2,
    CULL_ALL  = 2'd3
  } cull_mode_t;

  localparam int TRI_W = $bits(triangle_t);
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with a registered first-word-fall-through head
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      mem_count;
  logic             head_valid;
  logic             take, load_mem, load_direct, push_mem;

  // The head register refills from storage first, or straight from push when storage is empty.
  assign take        = !head_valid || pop;
  assign load_mem    = take && (mem_count != '0);
  assign load_direct = take && (mem_count == '0) && push;
  assign push_mem    = push && !load_direct;
  assign empty       = !head_valid;
  assign full        = (mem_count + (AW+1)'(head_valid)) == (AW+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      if (push_mem) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (load_mem) begin
        head   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end else if (load_direct) begin
        head <= push_data;
      end
      if (load_mem || load_direct) head_valid <= 1'b1;
      else if (pop)                head_valid <= 1'b0;
      mem_count <= mem_count + (AW+1)'(push_mem) - (AW+1)'(load_mem);
    end
  end
endmodule

// File: rtl/triangle_area.sv
// rtl/triangle_area.sv - 4-stage doubled signed area: (x2-x0)(y1-y0)-(x1-x0)(y2-y0)
// A negative result means clockwise winding; magnitude always fits AREA_W bits.
module triangle_area
  import graphics_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  triangle_t         tri_vertices,
  output logic              result_valid,
  output logic [AREA_W-1:0] area,
  output logic              negative
);
  localparam int DW = COORD_W + 1;

  logic [3:0]             valid_q;
  logic signed [DW-1:0]   dx1_q, dy1_q, dx2_q, dy2_q;
  logic signed [2*DW-1:0] pa_q, pb_q;
  logic signed [2*DW:0]   sum_q;

  function automatic logic signed [DW-1:0] diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= {valid_q[2:0], valid};
    dx1_q    <= diff(tri_vertices[1][0], tri_vertices[0][0]);
    dy1_q    <= diff(tri_vertices[1][1], tri_vertices[0][1]);
    dx2_q    <= diff(tri_vertices[2][0], tri_vertices[0][0]);
    dy2_q    <= diff(tri_vertices[2][1], tri_vertices[0][1]);
    pa_q     <= dx2_q * dy1_q;
    pb_q     <= dx1_q * dy2_q;
    sum_q    <= {pa_q[2*DW-1], pa_q} - {pb_q[2*DW-1], pb_q};
    negative <= sum_q[2*DW];
    area     <= AREA_W'(sum_q[2*DW] ? -sum_q : sum_q);
  end

  assign result_valid = valid_q[3];
endmodule

// File: rtl/valid_pipe.sv
// rtl/valid_pipe.sv - fixed-latency shift pipe carrying a valid bit and sideband data
module valid_pipe #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             delayed_valid,
  output logic [WIDTH-1:0] delayed_data
);
  logic [LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]   data_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
    data_q[0] <= data;
    for (int i = 1; i < LATENCY; i++) data_q[i] <= data_q[i-1];
  end

  assign delayed_valid = valid_q[LATENCY-1];
  assign delayed_data  = data_q[LATENCY-1];
endmodule

// File: rtl/triangle_cull.sv
// rtl/triangle_cull.sv - credit-admitted triangle scheduler with zero-area and winding cull
module triangle_cull
  import graphics_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AREA_LATENCY = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  triangle_t         vertices_in,
  input  logic [1:0]        cull_mode_in,
  output logic              valid_out,
  input  logic              ready_out,
  output triangle_t         vertices_out,
  output logic [AREA_W-1:0] area_out,
  output logic              negative_out,
  output logic [31:0]       culled_count_out
);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int SIDE_W  = TRI_W + 2;
  localparam int ENTRY_W = TRI_W + AREA_W + 1;

  logic [CW-1:0]      credits_q;
  logic               in_reset_q;
  logic               accept, pop, drop, push, cull;
  logic               area_valid, side_valid, res_valid, area_neg;
  logic               fifo_empty, fifo_full;
  logic [AREA_W-1:0]  area;
  logic [SIDE_W-1:0]  side_data;
  logic [ENTRY_W-1:0] head;
  triangle_t          side_vertices;
  cull_mode_t         side_mode;

  // Credits cover in-flight plus buffered triangles, so a result always has a FIFO slot.
  assign ready_in  = !in_reset_q && (credits_q != CW'(DEPTH));
  assign accept    = valid_in && ready_in;
  assign pop       = valid_out && ready_out;
  assign res_valid = area_valid && side_valid;
  assign drop      = res_valid && cull;
  assign push      = res_valid && !cull;

  assign side_vertices = side_data[SIDE_W-1:2];
  assign side_mode     = cull_mode_t'(side_data[1:0]);

  always_comb begin
    cull = (area == '0);
    case (side_mode)
      CULL_NEG: if (area_neg)  cull = 1'b1;
      CULL_POS: if (!area_neg) cull = 1'b1;
      CULL_ALL: cull = 1'b1;
      default:  ;
    endcase
  end

  triangle_area u_area (
    .clk          (clk_in),
    .rst          (rst_in),
    .valid        (accept),
    .tri_vertices (vertices_in),
    .result_valid (area_valid),
    .area         (area),
    .negative     (area_neg)
  );

  valid_pipe #(.WIDTH(SIDE_W), .LATENCY(AREA_LATENCY)) u_side (
    .clk           (clk_in),
    .rst           (rst_in),
    .valid         (accept),
    .data          ({vertices_in, cull_mode_in}),
    .delayed_valid (side_valid),
    .delayed_data  (side_data)
  );

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (push),
    .push_data ({side_vertices, area, area_neg}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign valid_out = !fifo_empty;
  assign {vertices_out, area_out, negative_out} = head;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      credits_q        <= '0;
      in_reset_q       <= 1'b1;
      culled_count_out <= '0;
    end else begin
      credits_q  <= credits_q + CW'(accept) - CW'(pop) - CW'(drop);
      in_reset_q <= 1'b0;
      if (drop) culled_count_out <= culled_count_out + 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && push) assert (!fifo_full);
  end
endmodule
